// File: rtl/onehot_sel_pkg.sv
// Shared types and limits for the one-hot selection decoder.
// Holds the output-register state encoding and the maximum supported condition count.
package onehot_sel_pkg;

  localparam int MAX_N = 32;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational index-to-one-hot decode with out-of-range flag; zero latency, no flow control.
// An index at or beyond N decodes to all-zero so downstream never sees a phantom selection.
module onehot_dec #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] idx,
  input  logic             none,
  output logic [N-1:0]     onehot,
  output logic             range_err
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = !none && (32'(idx) == i);
    end
  end

  assign range_err = !none && (32'(idx) >= N);

endmodule

// File: rtl/onehot_sel_decoder.sv
// Registered one-hot selection decoder: 1-cycle latency, single-entry valid/ready stage at full throughput.
// Holds the word while out_ready is low; ONEHOT_SEL_CHECK_EN adds the chk_err integrity monitor.
module onehot_sel_decoder
  import onehot_sel_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_none,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_onehot,
  output logic             out_none,
  output logic             err_range,
`ifdef ONEHOT_SEL_CHECK_EN
  output logic             chk_err,
`endif
  output logic [15:0]      xfer_cnt
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("onehot_sel_decoder: N out of supported range");
  end

  state_t         state;
  state_t         state_nxt;
  logic           in_xfer;
  logic           out_xfer;
  logic [N-1:0]   dec_onehot;
  logic           dec_range_err;

  onehot_dec #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .idx       (in_idx),
    .none      (in_none),
    .onehot    (dec_onehot),
    .range_err (dec_range_err)
  );

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (in_xfer) state_nxt = FULL;
      FULL:    if (out_xfer && !in_xfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = !out_valid || out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_onehot <= '0;
      out_none   <= 1'b0;
      err_range  <= 1'b0;
      xfer_cnt   <= '0;
    end else begin
      if (in_xfer) begin
        out_onehot <= dec_onehot;
        out_none   <= in_none;
        if (dec_range_err) err_range <= 1'b1;
      end
      if (out_xfer) xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

`ifdef ONEHOT_SEL_CHECK_EN
  // A presented word must be one-hot or zero, and a "no match" word must be zero.
  logic bad_word;
  assign bad_word = out_valid &&
                    (((out_onehot & (out_onehot - {{(N-1){1'b0}}, 1'b1})) != '0) ||
                     (out_none && (out_onehot != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        chk_err <= 1'b0;
    else if (bad_word) chk_err <= 1'b1;
  end

  a_word_ok: assert property (@(posedge clk) disable iff (!rst_n) !bad_word);
`endif

endmodule

// File: doc/onehot_sel_decoder.md
ONEHOT_SEL_DECODER -- requirements
Module: onehot_sel_decoder

Interface
REQ-001 Parameter N, default 8, number of selectable conditions (2..32).
REQ-002 Parameter IDX_W, default $clog2(N), index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  encoded selection present.
REQ-006 in_ready  output  1  decoder accepts the selection this cycle.
REQ-007 in_idx  input  IDX_W  encoded index of the matching condition.
REQ-008 in_none  input  1  no condition matched (unique0 case); in_idx ignored.
REQ-009 out_valid  output  1  decoded vector present.
REQ-010 out_ready  input  1  consumer takes the vector this cycle.
REQ-011 out_onehot  output  N  decoded selection, one-hot or all-zero.
REQ-012 out_none  output  1  decoded word represents "no match".
REQ-013 err_range  output  1  sticky: an in_idx >= N was accepted.
REQ-014 xfer_cnt  output  16  count of completed output transfers.

Function
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (single-entry pipeline register, full throughput).
REQ-017 Latency: accepted selection appears on out_* the following cycle.
REQ-018 in_none=1: out_onehot=0, out_none=1.
REQ-019 in_none=0, in_idx<N: out_onehot has only bit in_idx set, out_none=0.
REQ-020 in_none=0, in_idx>=N: out_onehot=0, out_none=0, err_range set and held until reset.
REQ-021 out_onehot/out_none SHALL stay stable while out_valid && !out_ready.
REQ-022 Simultaneous input and output transfer: new word loads, out_valid stays 1.
REQ-023 Output transfer without input transfer: out_valid falls to 0 next cycle.
REQ-024 xfer_cnt increments by 1 per output transfer, wraps 0xFFFF -> 0x0000.
REQ-025 State machine: EMPTY (out_valid=0) -> FULL on input transfer; FULL -> EMPTY on output transfer without input transfer; FULL -> FULL otherwise.

Reset
REQ-026 rst_n low SHALL immediately force: state EMPTY, out_valid=0, out_onehot=0, out_none=0, err_range=0, xfer_cnt=0.
REQ-027 A word held in FULL when reset asserts is discarded; in_ready=1 the first cycle after release.

Configuration
REQ-028 Macro ONEHOT_SEL_CHECK_EN defined: adds output chk_err (1 bit, sticky, reset 0), set if out_valid and out_onehot is not one-hot-or-zero, or out_none=1 with out_onehot nonzero; also a simulation assertion reporting the same.
REQ-029 Macro undefined: no chk_err port, no assertion, decode logic otherwise identical.

Structure
REQ-030 Shared package onehot_sel_pkg holds the state enum (EMPTY, FULL) and the MAX_N=32 constant.
REQ-031 One sub-module onehot_dec (combinational index-to-one-hot with range flag) is instantiated once.

Verification
REQ-032 Reset, then in_idx=3, in_none=0, out_ready=1 -> next cycle out_onehot=8'h08, out_valid=1, xfer_cnt=1 one cycle later.
REQ-033 in_none=1 -> out_onehot=8'h00, out_none=1, err_range=0.
REQ-034 N=6, in_idx=7 -> out_onehot=0, out_none=0, err_range=1 and still 1 after ten further valid words.
REQ-035 out_ready=0 for 5 cycles with word idx=5 held -> out_onehot=8'h20 stable, in_ready=0; release -> transfer, in_ready=1.
REQ-036 Back-to-back idx 0..7 with out_ready=1 -> one word per cycle, outputs 8'h01..8'h80 in order, xfer_cnt=8.
REQ-037 rst_n pulled low while FULL -> out_valid=0 immediately, xfer_cnt=0, in_ready=1 after release.
